ahb_slave_arbiter: RTL and testbench

AHB_SLAVE_ARBITER -- requirements
Module: ahb_slave_arbiter

---
 rtl/ahb_slave_arbiter.sv | 112 +++++++++++
 tb/tb_ahb_slave_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter: picks one address-phase owner among the masters that target this slave,
// keeps bursts and locked sequences together, and tracks the data-phase owner for return steering.

package AHB_package;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_type;
endpackage

module ahb_slave_arbiter
  import AHB_package::*;
#(
  parameter int unsigned SLAVE_X_MASTER_NUM = 2,
  parameter int unsigned MIDX_W             = $clog2(SLAVE_X_MASTER_NUM)
) (
  input  logic                                      hclk,
  input  logic                                      hreset_n,
  input  logic       [SLAVE_X_MASTER_NUM-1:0]       hreq,
  input  htrans_type [SLAVE_X_MASTER_NUM-1:0]       htrans,
  input  logic       [SLAVE_X_MASTER_NUM-1:0]       hmastlock,
  input  logic                                      hready_slv,
  output logic       [SLAVE_X_MASTER_NUM-1:0]       hgrant,
  output logic       [MIDX_W-1:0]                   hmaster_addr,
  output logic                                      hsel,
  output logic       [MIDX_W-1:0]                   hmaster_data,
  output logic                                      data_active
);

  typedef enum logic {FREE, OWNED} state_t;

  state_t                        state_q, state_d;
  logic [SLAVE_X_MASTER_NUM-1:0] grant_d;
  logic [MIDX_W-1:0]             addr_d;
  logic                          sel_d;
  logic [MIDX_W-1:0]             rr_q, rr_d;
  logic                          dact_d;
  logic                          hold;
  logic                          found;
  logic [MIDX_W-1:0]             win;
  logic [MIDX_W-1:0]             cand;
  htrans_type                    owner_htrans;

  always_comb begin
    state_d      = state_q;
    grant_d      = hgrant;
    addr_d       = hmaster_addr;
    sel_d        = hsel;
    rr_d         = rr_q;
    found        = 1'b0;
    win          = '0;
    cand         = '0;
    owner_htrans = htrans[hmaster_addr];

    hold = (state_q == OWNED) && hreq[hmaster_addr] &&
           ((owner_htrans == SEQ) || (owner_htrans == BUSY) || hmastlock[hmaster_addr]);

    // Round-robin scan starting just after the last granted master; the
    // last candidate visited is rr_q itself, so a sole requester is re-granted.
    for (int unsigned i = 1; i <= SLAVE_X_MASTER_NUM; i++) begin
      cand = MIDX_W'((32'(rr_q) + i) % SLAVE_X_MASTER_NUM);
      if (!found && hreq[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end

    if (!hold) begin
      if (found) begin
        state_d      = OWNED;
        grant_d      = '0;
        grant_d[win] = 1'b1;
        addr_d       = win;
        sel_d        = 1'b1;
        rr_d         = win;
      end else begin
        state_d = FREE;
        grant_d = '0;
        sel_d   = 1'b0;
      end
    end

    dact_d = hsel && ((owner_htrans == NONSEQ) || (owner_htrans == SEQ));
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q      <= FREE;
      hgrant       <= '0;
      hmaster_addr <= '0;
      hsel         <= 1'b0;
      rr_q         <= MIDX_W'(SLAVE_X_MASTER_NUM - 1);
      hmaster_data <= '0;
      data_active  <= 1'b0;
    end else if (hready_slv) begin
      state_q      <= state_d;
      hgrant       <= grant_d;
      hmaster_addr <= addr_d;
      hsel         <= sel_d;
      rr_q         <= rr_d;
      hmaster_data <= hmaster_addr;
      data_active  <= dact_d;
    end
  end

`ifndef SYNTHESIS
  a_grant_onehot0: assert property (@(posedge hclk) disable iff (!hreset_n) $onehot0(hgrant));
`endif

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Scenario bench for ahb_slave_arbiter with two masters; each row's expected
// outputs are queued when it is driven and compared after the following edge.

module tb_ahb_slave_arbiter;
  import AHB_package::*;

  localparam int unsigned N = 2;
  localparam logic [1:0] ID = 2'b00, BZ = 2'b01, NS = 2'b10, SQ = 2'b11;

  logic                hclk;
  logic                hreset_n;
  logic [N-1:0]        hreq;
  htrans_type [N-1:0]  htrans;
  logic [N-1:0]        hmastlock;
  logic                hready_slv;
  logic [N-1:0]        hgrant;
  logic [0:0]          hmaster_addr;
  logic                hsel;
  logic [0:0]          hmaster_data;
  logic                data_active;

  // {hgrant, hmaster_addr, hsel, hmaster_data, data_active}
  logic [5:0] obs;
  assign obs = {hgrant, hmaster_addr, hsel, hmaster_data, data_active};

  typedef struct packed {
    logic [1:0] req;
    logic [1:0] t0;
    logic [1:0] t1;
    logic [1:0] lock;
    logic       rdy;
    logic [5:0] exp;
  } row_t;

  logic [5:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  ahb_slave_arbiter #(.SLAVE_X_MASTER_NUM(N)) dut (
    .hclk        (hclk),
    .hreset_n    (hreset_n),
    .hreq        (hreq),
    .htrans      (htrans),
    .hmastlock   (hmastlock),
    .hready_slv  (hready_slv),
    .hgrant      (hgrant),
    .hmaster_addr(hmaster_addr),
    .hsel        (hsel),
    .hmaster_data(hmaster_data),
    .data_active (data_active)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic drive(input row_t r);
    hreq       = r.req;
    htrans[0]  = htrans_type'(r.t0);
    htrans[1]  = htrans_type'(r.t1);
    hmastlock  = r.lock;
    hready_slv = r.rdy;
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    hreset_n = 1'b0;
    drive('{2'b11, NS, NS, 2'b00, 1'b1, 6'b0});
    exp_q.push_back(6'b00_0_0_0_0);
    #2;
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_no_clock: got %b expected %b", obs, exp); end
    exp_q.push_back(6'b00_0_0_0_0);
    @(posedge hclk); #1;
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_held_edge: got %b expected %b", obs, exp); end
    hreset_n = 1'b1;
  endtask

  task automatic test_contention();
    row_t rows [3];
    logic [5:0] exp;
    rows = '{'{2'b11, NS, NS, 2'b00, 1'b1, 6'b01_0_1_0_0},
             '{2'b11, NS, NS, 2'b00, 1'b1, 6'b10_1_1_0_1},
             '{2'b11, NS, NS, 2'b00, 1'b1, 6'b01_0_1_1_1}};
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].exp);
      @(posedge hclk); #1;
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL contention[%0d]: got %b expected %b", i, obs, exp); end
    end
  endtask

  task automatic test_burst_hold();
    row_t rows [6];
    logic [5:0] exp;
    rows = '{'{2'b11, NS, NS, 2'b00, 1'b1, 6'b10_1_1_0_1},
             '{2'b11, NS, SQ, 2'b00, 1'b1, 6'b10_1_1_1_1},
             '{2'b11, NS, SQ, 2'b00, 1'b1, 6'b10_1_1_1_1},
             '{2'b11, NS, BZ, 2'b00, 1'b1, 6'b10_1_1_1_0},
             '{2'b11, NS, SQ, 2'b00, 1'b1, 6'b10_1_1_1_1},
             '{2'b11, NS, ID, 2'b00, 1'b1, 6'b01_0_1_1_0}};
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].exp);
      @(posedge hclk); #1;
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL burst_hold[%0d]: got %b expected %b", i, obs, exp); end
    end
  endtask

  task automatic test_wait_states();
    row_t rows [4];
    logic [5:0] exp;
    rows = '{'{2'b10, NS, NS, 2'b00, 1'b0, 6'b01_0_1_1_0},
             '{2'b00, NS, NS, 2'b00, 1'b0, 6'b01_0_1_1_0},
             '{2'b10, NS, NS, 2'b00, 1'b0, 6'b01_0_1_1_0},
             '{2'b10, NS, NS, 2'b00, 1'b1, 6'b10_1_1_0_1}};
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].exp);
      @(posedge hclk); #1;
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL wait_states[%0d]: got %b expected %b", i, obs, exp); end
    end
  endtask

  task automatic test_lock();
    row_t rows [4];
    logic [5:0] exp;
    rows = '{'{2'b11, NS, NS, 2'b01, 1'b1, 6'b01_0_1_1_1},
             '{2'b11, NS, NS, 2'b01, 1'b1, 6'b01_0_1_0_1},
             '{2'b11, NS, NS, 2'b01, 1'b1, 6'b01_0_1_0_1},
             '{2'b11, NS, NS, 2'b00, 1'b1, 6'b10_1_1_0_1}};
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].exp);
      @(posedge hclk); #1;
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL lock[%0d]: got %b expected %b", i, obs, exp); end
    end
  endtask

  task automatic test_release();
    row_t rows [2];
    logic [5:0] exp;
    rows = '{'{2'b00, NS, NS, 2'b00, 1'b1, 6'b00_1_0_1_1},
             '{2'b00, NS, NS, 2'b00, 1'b1, 6'b00_1_0_1_0}};
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].exp);
      @(posedge hclk); #1;
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL release[%0d]: got %b expected %b", i, obs, exp); end
    end
  endtask

  task automatic test_sole_requester();
    row_t rows [2];
    logic [5:0] exp;
    rows = '{'{2'b10, NS, NS, 2'b00, 1'b1, 6'b10_1_1_1_0},
             '{2'b10, NS, NS, 2'b00, 1'b1, 6'b10_1_1_1_1}};
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].exp);
      @(posedge hclk); #1;
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL sole_requester[%0d]: got %b expected %b", i, obs, exp); end
    end
  endtask

  task automatic test_reset_mid_burst();
    row_t pre [2];
    row_t post [3];
    logic [5:0] exp;
    pre  = '{'{2'b10, NS, SQ, 2'b00, 1'b1, 6'b10_1_1_1_1},
             '{2'b11, NS, SQ, 2'b00, 1'b0, 6'b10_1_1_1_1}};
    post = '{'{2'b11, NS, NS, 2'b00, 1'b0, 6'b00_0_0_0_0},
             '{2'b11, NS, NS, 2'b00, 1'b1, 6'b01_0_1_0_0},
             '{2'b11, NS, NS, 2'b00, 1'b1, 6'b10_1_1_0_1}};
    foreach (pre[i]) begin
      drive(pre[i]);
      exp_q.push_back(pre[i].exp);
      @(posedge hclk); #1;
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL mid_burst_pre[%0d]: got %b expected %b", i, obs, exp); end
    end
    hreset_n = 1'b0;
    exp_q.push_back(6'b00_0_0_0_0);
    #2;
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL mid_burst_async_reset: got %b expected %b", obs, exp); end
    @(posedge hclk); #1;
    hreset_n = 1'b1;
    foreach (post[i]) begin
      drive(post[i]);
      exp_q.push_back(post[i].exp);
      @(posedge hclk); #1;
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL after_reset[%0d]: got %b expected %b", i, obs, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_burst_hold();
    test_wait_states();
    test_lock();
    test_release();
    test_sole_requester();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
